// File: rtl/reg_select_bank_pkg.sv
// Shared types for reg_select_bank: sequencer state and selector sizing.
// Latency: none (types and functions only).
// Backpressure: none.
package reg_select_bank_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // One extra selector code is reserved for the external buffer slot.
  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reg_bank_clear_seq.sv
// Bulk-clear sequencer: walks cnt over every register and gates write acceptance.
// Latency: busy rises 1 cycle after clear and stays high for NUM_REGS cycles.
// Backpressure: wr_ready drops combinationally on clear and stays low while busy.
module reg_bank_clear_seq
  import reg_select_bank_pkg::*;
#(
  parameter int NUM_REGS = 3,
  parameter int SEL_W    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  output logic             busy,
  output logic             wr_ready,
  output logic [SEL_W-1:0] cnt
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  // clear wins over a same-cycle write request.
  assign wr_ready = (state_q == IDLE) && !clear;
  assign cnt      = cnt_q;

endmodule

// File: rtl/reg_select_bank.sv
// Register bank with valid/ready writes, registered selectable read, bulk clear and LED monitor.
// Latency: 1 cycle write-to-regs_flat and rd_sel-to-rd_data; same-index bypass when REG_SELECT_BANK_FORWARD_EN.
// Backpressure: wr_ready low during clear request and the NUM_REGS-cycle clear sequence.
module reg_select_bank
  import reg_select_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 3,
  parameter int SEL_W    = sel_width(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      wr_err,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [WIDTH-1:0]          rd_data,
  input  logic [WIDTH-1:0]          ext_in,
  input  logic                      clear,
  output logic                      busy,
  output logic [WIDTH-1:0]          led_out,
  output logic [NUM_REGS*WIDTH-1:0] regs_flat
);

  localparam logic [SEL_W-1:0] EXT_SEL = SEL_W'(NUM_REGS);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] rd_next;
  logic [SEL_W-1:0] cnt;
  logic             wr_acc;
  logic             wr_ok;

  reg_bank_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_clear_seq (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .busy     (busy),
    .wr_ready (wr_ready),
    .cnt      (cnt)
  );

  assign wr_acc = wr_valid && wr_ready;
  assign wr_ok  = wr_acc && (wr_sel < EXT_SEL);

  // Writes are never accepted while busy, so clear and write never collide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (busy && (cnt == SEL_W'(i)))
          regs_q[i] <= '0;
        else if (wr_ok && (wr_sel == SEL_W'(i)))
          regs_q[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) rd_next = regs_q[i];
    end
    if (rd_sel == EXT_SEL) rd_next = ext_in;
`ifdef REG_SELECT_BANK_FORWARD_EN
    if (wr_ok && (wr_sel == rd_sel)) rd_next = wr_data;
    if (busy && (rd_sel == cnt)) rd_next = '0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
      led_out <= '0;
      wr_err  <= 1'b0;
    end else begin
      rd_data <= rd_next;
      led_out <= wr_data;
      wr_err  <= wr_acc && (wr_sel >= EXT_SEL);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_reg_select_bank.sv
// Directed bench for reg_select_bank (WIDTH=8, NUM_REGS=3).
module tb_reg_select_bank;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;
  logic [7:0]  ext_in;
  logic        clear;
  logic        busy;
  logic [7:0]  led_out;
  logic [23:0] regs_flat;

  int checks   = 0;
  int failures = 0;

  reg_select_bank #(.WIDTH(8), .NUM_REGS(3)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .ext_in    (ext_in),
    .clear     (clear),
    .busy      (busy),
    .led_out   (led_out),
    .regs_flat (regs_flat)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] sel, input logic [7:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    rd_sel   = '0;
    ext_in   = '0;
    clear    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_rd_data", rd_data, 0);
    check("rst_led", led_out, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_regs", regs_flat, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 1);
    reset_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    check("idle_wr_ready", wr_ready, 1);

    // Basic writes and reads
    write(2'd0, 8'h5A);
    check("wr0_regs", regs_flat, 24'h00005A);
    check("wr0_led", led_out, 8'h5A);
    write(2'd1, 8'hC3);
    write(2'd2, 8'h11);
    check("wr_all_regs", regs_flat, 24'h11C35A);
    ext_in = 8'h7E;
    rd_sel = 2'd0; tick(); check("rd0", rd_data, 8'h5A);
    rd_sel = 2'd1; tick(); check("rd1", rd_data, 8'hC3);
    rd_sel = 2'd2; tick(); check("rd2", rd_data, 8'h11);
    rd_sel = 2'd3; tick(); check("rd_ext", rd_data, 8'h7E);
    ext_in = 8'h81; tick(); check("rd_ext_live", rd_data, 8'h81);

    // Out-of-range writes: one pulse each, back-to-back pulses stay high
    write(2'd3, 8'hAA);
    check("bad_err", wr_err, 1);
    check("bad_regs", regs_flat, 24'h11C35A);
    tick();
    check("bad_err_drop", wr_err, 0);
    wr_valid = 1'b1; wr_sel = 2'd3; wr_data = 8'hAB;
    tick(); check("bad2_err_a", wr_err, 1);
    tick(); check("bad2_err_b", wr_err, 1);
    wr_valid = 1'b0;
    tick(); check("bad2_err_end", wr_err, 0);
    check("bad2_regs", regs_flat, 24'h11C35A);

    // Bulk clear with a write request on the same cycle; request held until accepted
    write(2'd0, 8'hFF);
    write(2'd1, 8'hFF);
    write(2'd2, 8'hFF);
    check("ff_regs", regs_flat, 24'hFFFFFF);
    clear = 1'b1; wr_valid = 1'b1; wr_sel = 2'd0; wr_data = 8'h55;
    #1 check("clr_ready_comb", wr_ready, 0);
    tick();
    clear = 1'b0;
    check("clr_c1_busy", busy, 1);
    check("clr_c1_regs", regs_flat, 24'hFFFFFF);
    check("clr_c1_ready", wr_ready, 0);
    tick();
    clear = 1'b1;
    check("clr_c2_busy", busy, 1);
    check("clr_c2_regs", regs_flat, 24'hFFFF00);
    tick();
    clear = 1'b0;
    check("clr_c3_busy", busy, 1);
    check("clr_c3_regs", regs_flat, 24'hFF0000);
    tick();
    check("clr_done_busy", busy, 0);
    check("clr_done_regs", regs_flat, 24'h000000);
    check("clr_done_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check("clr_after_write", regs_flat, 24'h000055);
    check("clr_after_busy", busy, 0);

    // Same-cycle write and read of one index
    write(2'd1, 8'h77);
    rd_sel = 2'd1; tick(); check("fwd_pre", rd_data, 8'h77);
    wr_valid = 1'b1; wr_sel = 2'd1; wr_data = 8'h3C;
    tick();
    wr_valid = 1'b0;
`ifdef REG_SELECT_BANK_FORWARD_EN
    check("fwd_same_cycle", rd_data, 8'h3C);
`else
    check("fwd_same_cycle", rd_data, 8'h77);
`endif
    tick();
    check("fwd_next_cycle", rd_data, 8'h3C);
    check("fwd_regs", regs_flat, 24'h003C55);

    // Reset during the second cycle of a clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("mid_clr_busy", busy, 1);
    check("mid_clr_regs", regs_flat, 24'h003C00);
    check("mid_clr_rd", rd_data, 8'h3C);
    check("mid_clr_led", led_out, 8'h3C);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_regs", regs_flat, 0);
    check("mid_rst_rd", rd_data, 0);
    check("mid_rst_led", led_out, 0);
    check("mid_rst_err", wr_err, 0);
    check("mid_rst_ready", wr_ready, 1);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", wr_ready, 1);
    check("post_rst_regs", regs_flat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_select_bank.md
# reg_select_bank

Parametrised register bank with a selectable read path for the simple processor datapath. It holds the general-purpose registers and the instruction byte, and accepts writes through a valid/ready handshake. It returns one selected register, or the external buffer input, on a registered read port. A sequenced bulk-clear operation and a registered LED monitor of the write bus are included.

## Interface
- WIDTH, 8, data width of every register and bus
- NUM_REGS, 3, number of writable registers (index 0 = A, 1 = B, 2 = instruction byte by convention)
- SEL_W, $clog2(NUM_REGS+1), selector width (derived; not overridden)
- One clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  bank can accept a write this cycle
- wr_sel  in  SEL_W  write target index
- wr_data  in  WIDTH  write data
- wr_err  out  1  one-cycle pulse: accepted write had wr_sel >= NUM_REGS
- rd_sel  in  SEL_W  read selector; index NUM_REGS = ext_in
- rd_data  out  WIDTH  registered read result
- ext_in  in  WIDTH  read-only external buffer slot
- clear  in  1  start bulk clear
- busy  out  1  bulk clear in progress
- led_out  out  WIDTH  registered copy of wr_data, every cycle
- regs_flat  out  NUM_REGS*WIDTH  live register contents, reg i at bits [i*WIDTH +: WIDTH]

## Operation
- States: IDLE, CLEAR.
- IDLE → CLEAR when clear=1. The clear counter loads 0.
- CLEAR: zero reg[cnt] each cycle and increment cnt. After zeroing reg[NUM_REGS-1], return to IDLE. clear is ignored while in CLEAR.
- busy = (state==CLEAR).
- wr_ready = (state==IDLE) && !clear. This is combinational from clear, and clear has priority over a same-cycle write.
- Write accepted when wr_valid && wr_ready:
  - wr_sel < NUM_REGS: reg[wr_sel] ← wr_data.
  - Otherwise: data dropped, wr_err=1 next cycle.
- wr_valid while not ready: no effect. The master holds wr_sel/wr_data until accepted.
- Read, every cycle:
  - rd_data ← reg[rd_sel] for rd_sel < NUM_REGS.
  - rd_data ← ext_in for rd_sel == NUM_REGS.
  - rd_data ← 0 for rd_sel > NUM_REGS.
- led_out ← wr_data every cycle, independent of handshake and state.
- Reset (any time, including mid-CLEAR): all regs 0, rd_data 0, led_out 0, wr_err 0, state IDLE, cnt 0. Consequently wr_ready=1 and busy=0 once reset deasserts (with clear=0).

## Timing
- Write to register: visible on regs_flat 1 cycle after acceptance.
- Read latency: 1 cycle from rd_sel to rd_data.
- Bulk clear: busy high for exactly NUM_REGS cycles. The first write can be accepted on the cycle busy falls.
- wr_err is asserted for exactly one cycle per bad accepted write. Back-to-back bad writes give consecutive pulses.
- Same-cycle write and read of the same index: forwarding behaviour is set by the macro below.

## Configuration
- REG_SELECT_BANK_FORWARD_EN defined:
  - An accepted write whose wr_sel equals rd_sel (< NUM_REGS) in the same cycle drives rd_data with wr_data.
  - In CLEAR, a read of reg[cnt] returns 0 in that cycle.
- Not defined: rd_data returns the pre-write (pre-clear) register value. The new value appears on the next read.

## Structure
- Package reg_select_bank_pkg holds:
  - the state enum (IDLE, CLEAR)
  - the selector-width function used to derive SEL_W
- Sub-module reg_bank_clear_seq holds the state register, clear counter, busy and the wr_ready gating.
- The register array, read mux and led_out stay in the top.

## Test plan
- Reset with WIDTH=8, NUM_REGS=3, then idle → all outputs 0, wr_ready=1, busy=0.
- Write 0x5A to sel 0, then 0xC3 to sel 1, 0x11 to sel 2; read sels 0..3 with ext_in=0x7E → rd_data 0x5A, 0xC3, 0x11, 0x7E, each 1 cycle after rd_sel.
- Write 0xAA with wr_sel=3 → no register changes, wr_err pulses once; rd_sel=5 (if SEL_W permits) → rd_data 0.
- Load all regs to 0xFF, pulse clear with wr_valid=1 on the same cycle → write refused, busy high 3 cycles, regs zero in order 0,1,2, wr_ready returns after.
- Write 0x3C to sel 1 with rd_sel=1 in the same cycle:
  - with REG_SELECT_BANK_FORWARD_EN, rd_data=0x3C next cycle;
  - without it, rd_data=old value, then 0x3C a cycle later.
- Assert reset_n=0 in the second cycle of CLEAR → immediate IDLE, all outputs 0. After release, clear=0 gives busy=0.
